// File: rtl/win_scanner.sv
// -----------------------------------------------------------------------------
// win_scanner
//   Sequential tic-tac-toe board evaluator. A start request snapshots the
//   board; one of the eight lines (rows, columns, diagonals) is then checked
//   per clock. When the scan finishes, result/win_line/invalid are updated
//   together and done pulses for one cycle.
//
// Parameters
//   EARLY_EXIT : 0 = always scan all 8 lines, 1 = stop on the first winning line
//
// Ports
//   clock    : system clock, rising edge
//   reset    : asynchronous active-high reset
//   board    : 9 cells x 2 bits, cell i at [2i+1:2i] (00 blank, 01 X, 10 O, 11 rsvd)
//   start    : evaluate the current board (accepted only when idle)
//   busy     : high while a scan is in progress
//   done     : one-cycle pulse when the result outputs have just updated
//   result   : 00 none, 01 X wins, 10 O wins, 11 draw
//   win_line : lowest-numbered winning line (0 unless result is 01/10)
//   invalid  : both players own a complete line
// -----------------------------------------------------------------------------
module win_scanner #(
    parameter int EARLY_EXIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] board,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic [2:0]  win_line,
    output logic        invalid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [17:0] r_snap;
    logic [2:0]  r_cnt;
    logic        r_xf;
    logic        r_of;
    logic        r_rec;      // a winning line index has been recorded
    logic [2:0]  r_wl;       // first winning line seen this scan

    logic [11:0] w_cells;
    logic [1:0]  w_c0, w_c1, w_c2;
    logic        w_xwin, w_owin;
    logic        w_xf_n, w_of_n;
    logic        w_full;
    logic        w_last;
    logic [2:0]  w_line_n;

    // Three 4-bit cell indices of a line, first cell in the top nibble.
    function automatic logic [11:0] line_cells(input logic [2:0] l);
        logic [11:0] v;
        v = 12'h000;
        case (l)
            3'd0: v = {4'd0, 4'd1, 4'd2};
            3'd1: v = {4'd3, 4'd4, 4'd5};
            3'd2: v = {4'd6, 4'd7, 4'd8};
            3'd3: v = {4'd0, 4'd3, 4'd6};
            3'd4: v = {4'd1, 4'd4, 4'd7};
            3'd5: v = {4'd2, 4'd5, 4'd8};
            3'd6: v = {4'd0, 4'd4, 4'd8};
            3'd7: v = {4'd2, 4'd4, 4'd6};
            default: v = 12'h000;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
        return b[{i, 1'b0} +: 2];
    endfunction

    assign w_cells = line_cells(r_cnt);
    assign w_c0    = cell_at(r_snap, w_cells[11:8]);
    assign w_c1    = cell_at(r_snap, w_cells[7:4]);
    assign w_c2    = cell_at(r_snap, w_cells[3:0]);

    // Exact-match compare: RSVD (11) can never complete a line.
    assign w_xwin  = (w_c0 == 2'b01) && (w_c1 == 2'b01) && (w_c2 == 2'b01);
    assign w_owin  = (w_c0 == 2'b10) && (w_c1 == 2'b10) && (w_c2 == 2'b10);
    assign w_xf_n  = r_xf | w_xwin;
    assign w_of_n  = r_of | w_owin;

    // The line being evaluated wins only if nothing earlier was recorded.
    assign w_line_n = r_rec ? r_wl : r_cnt;

    assign w_last = (r_cnt == 3'd7) || ((EARLY_EXIT != 0) && (w_xwin || w_owin));

    // Board is full when every cell is X or O (bits differ); blank and RSVD both block a draw.
    always_comb begin
        w_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (!(^r_snap[2*i +: 2])) w_full = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_snap   <= '0;
            r_cnt    <= '0;
            r_xf     <= 1'b0;
            r_of     <= 1'b0;
            r_rec    <= 1'b0;
            r_wl     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 2'b00;
            win_line <= 3'd0;
            invalid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_snap  <= board;
                        r_cnt   <= 3'd0;
                        r_xf    <= 1'b0;
                        r_of    <= 1'b0;
                        r_rec   <= 1'b0;
                        r_wl    <= 3'd0;
                        busy    <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_xf <= w_xf_n;
                    r_of <= w_of_n;
                    if (!r_rec && (w_xwin || w_owin)) begin
                        r_rec <= 1'b1;
                        r_wl  <= r_cnt;
                    end
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                        if (w_xf_n && w_of_n) begin
                            result   <= 2'b00;
                            win_line <= 3'd0;
                            invalid  <= 1'b1;
                        end else if (w_xf_n) begin
                            result   <= 2'b01;
                            win_line <= w_line_n;
                            invalid  <= 1'b0;
                        end else if (w_of_n) begin
                            result   <= 2'b10;
                            win_line <= w_line_n;
                            invalid  <= 1'b0;
                        end else begin
                            result   <= w_full ? 2'b11 : 2'b00;
                            win_line <= 3'd0;
                            invalid  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_win_scanner.sv
// -----------------------------------------------------------------------------
// tb_win_scanner
//   Drives two scanners (full scan and early-exit) sharing clock, reset and
//   board, and checks their outputs against a line-table model of the game.
// -----------------------------------------------------------------------------
module tb_win_scanner;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;
    localparam logic [1:0] R = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] board = '0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;

    logic        busy0, done0, inv0;
    logic [1:0]  res0;
    logic [2:0]  wl0;
    logic        busy1, done1, inv1;
    logic [1:0]  res1;
    logic [2:0]  wl1;

    int tests = 0;
    int fails = 0;

    int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    always #5 clock = ~clock;

    win_scanner #(.EARLY_EXIT(0)) dut0 (
        .clock(clock), .reset(reset), .board(board), .start(start0),
        .busy(busy0), .done(done0), .result(res0), .win_line(wl0), .invalid(inv0)
    );

    win_scanner #(.EARLY_EXIT(1)) dut1 (
        .clock(clock), .reset(reset), .board(board), .start(start1),
        .busy(busy1), .done(done1), .result(res1), .win_line(wl1), .invalid(inv1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Game outcome straight from the rules: who owns a full line, first such
    // line, whether the board is full, and how many cycles the scan takes.
    function automatic void model(input logic [17:0] b, input int ee,
                                  output logic [1:0] res, output logic [2:0] wl,
                                  output logic inv, output int lat);
        bit xs = 0, os = 0, full = 1;
        int first = -1;
        lat = 8;
        for (int l = 0; l < 8; l++) begin
            int nx = 0, no = 0;
            for (int k = 0; k < 3; k++) begin
                logic [1:0] c;
                c = b[2*LINES[l][k] +: 2];
                if (c == X) nx++;
                if (c == O) no++;
            end
            if (nx == 3) xs = 1;
            if (no == 3) os = 1;
            if (first < 0 && (nx == 3 || no == 3)) first = l;
            if (ee != 0 && (nx == 3 || no == 3)) begin
                lat = l + 1;
                break;
            end
        end
        for (int i = 0; i < 9; i++) begin
            if (b[2*i +: 2] == B || b[2*i +: 2] == R) full = 0;
        end
        inv = 1'b0;
        if (xs && os)      begin res = 2'b00; inv = 1'b1; end
        else if (xs)       res = 2'b01;
        else if (os)       res = 2'b10;
        else if (full)     res = 2'b11;
        else               res = 2'b00;
        wl = (res == 2'b01 || res == 2'b10) ? 3'(first) : 3'd0;
    endfunction

    // One complete scan on the selected instance; the live board is scrambled
    // right after the start edge so only the snapshot can produce the result.
    task automatic do_scan(input int ee, input logic [17:0] b, input bit skip_wait, input string tag);
        logic [1:0] er; logic [2:0] ew; logic ei; int el;
        int n;
        model(b, ee, er, ew, ei, el);
        if (!skip_wait) @(negedge clock);
        board = b;
        if (ee != 0) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        board = 18'($urandom);
        chk({tag, ".busy_on"}, ee != 0 ? busy1 : busy0, 1);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clock);
            #1;
            if ((ee != 0 ? done1 : done0) === 1'b1) begin
                n = i;
                break;
            end
        end
        chk({tag, ".latency"}, n, el);
        chk({tag, ".busy_at_done"}, ee != 0 ? busy1 : busy0, 0);
        chk({tag, ".result"},   ee != 0 ? res1 : res0, er);
        chk({tag, ".win_line"}, ee != 0 ? wl1 : wl0, ew);
        chk({tag, ".invalid"},  ee != 0 ? inv1 : inv0, ei);
        @(posedge clock);
        #1;
        chk({tag, ".done_drop"}, ee != 0 ? done1 : done0, 0);
    endtask

    function automatic logic [17:0] rand_board();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) begin
            int r;
            r = $urandom_range(0, 9);
            b[2*i +: 2] = (r == 0) ? B : (r == 1) ? R : (r < 6) ? X : O;
        end
        return b;
    endfunction

    initial begin
        int d_cnt, d_first, d_second;
        logic [17:0] hb;

        // reset state
        #1;
        chk("rst.busy0", busy0, 0);   chk("rst.done0", done0, 0);
        chk("rst.res0", res0, 0);     chk("rst.wl0", wl0, 0);
        chk("rst.inv0", inv0, 0);     chk("rst.busy1", busy1, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // directed boards (cells listed 8..0)
        do_scan(0, 18'b0, 0, "empty");
        do_scan(0, {B,B,X,B,X,B,X,B,B}, 0, "x_anti");
        do_scan(0, {B,B,B,O,O,O,X,X,X}, 0, "both");
        do_scan(0, {X,X,O,O,O,X,X,O,X}, 0, "draw");
        do_scan(0, {R,X,O,O,O,X,X,O,X}, 0, "rsvd");
        do_scan(0, {B,O,B,B,O,B,B,O,B}, 0, "o_col1");
        do_scan(1, {B,B,B,B,B,B,X,X,X}, 0, "ee_row0");
        do_scan(1, {B,B,B,O,O,O,X,X,X}, 0, "ee_both");
        do_scan(1, {X,X,O,O,O,X,X,O,X}, 0, "ee_draw");

        // start held for 20 cycles: exactly two back-to-back scans
        hb = rand_board();
        @(negedge clock);
        board = hb;
        start0 = 1'b1;
        @(posedge clock);
        d_cnt = 0; d_first = -1; d_second = -1;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clock);
            #1;
            if (done0) begin
                d_cnt++;
                if (d_first < 0) d_first = i; else d_second = i;
            end
            if (i == 9)  chk("held.busy_done", busy0, 0);
            if (i == 10) chk("held.busy_rescan", busy0, 1);
            if (i == 19) start0 = 1'b0;
            if (i == 22) chk("held.no_third", busy0, 0);
        end
        chk("held.done_count", d_cnt, 2);
        chk("held.done_first", d_first, 8);
        chk("held.done_second", d_second, 18);

        // reset in the middle of a scan, following a scan that left O_WIN
        do_scan(0, {B,O,B,B,O,B,B,O,B}, 0, "pre_rst");
        @(negedge clock);
        board = {X,X,X,B,B,B,B,B,B};
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst.busy", busy0, 0);
        chk("mid_rst.done", done0, 0);
        chk("mid_rst.result", res0, 0);
        chk("mid_rst.win_line", wl0, 0);
        chk("mid_rst.invalid", inv0, 0);
        @(negedge clock);
        reset = 1'b0;
        do_scan(0, {B,B,X,B,X,B,X,B,B}, 1, "post_rst");

        // randomized boards on both instances
        for (int t = 0; t < 30; t++) begin
            do_scan(0, rand_board(), 0, "rand_full");
            do_scan(1, rand_board(), 0, "rand_ee");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
